// File: rtl/score_tally_if.sv
// score_tally_if: groups the score accumulator's keycode/lane inputs and its
// tally/display outputs into one bundle.
//   master : drives keycode and score_in, observes the tally outputs
//   slave  : the score_tally block itself
interface score_tally_if #(
  parameter int N_LANES = 64
);
  logic [7:0]         keycode;
  logic [N_LANES-1:0] score_in;
  logic               running;
  logic [13:0]        score_total;
  logic [9:0]         hit_count;
  logic [7:0]         combo;
  logic [7:0]         max_combo;
  logic               hit_pulse;
  logic [15:0]        score_bcd;
  logic               bcd_busy;

  modport master (
    output keycode, score_in,
    input  running, score_total, hit_count, combo, max_combo,
           hit_pulse, score_bcd, bcd_busy
  );

  modport slave (
    input  keycode, score_in,
    output running, score_total, hit_count, combo, max_combo,
           hit_pulse, score_bcd, bcd_busy
  );
endinterface

// File: rtl/score_tally.sv
// score_tally: rhythm-game score accumulator.
// Edge-detects per-lane dropper score levels, accumulates score / hit count /
// combo streak while running, and serially converts the score to BCD.
// Ports:
//   frame_clk : sole clock, rising edge
//   Reset_n   : asynchronous active-low reset
//   bus       : score_tally_if.slave
//     keycode (8h2c start, 8h01 back to idle), score_in[N_LANES]
//     running, score_total (sat 9999), hit_count (sat 1023), combo (sat 255),
//     max_combo, hit_pulse, score_bcd (4 digits), bcd_busy
module score_tally #(
  parameter int N_LANES      = 64,
  parameter int HIT_POINTS   = 10,
  parameter int BONUS_POINTS = 5,
  parameter int COMBO_BONUS  = 10,
  parameter int COMBO_WINDOW = 120
) (
  input logic          frame_clk,
  input logic          Reset_n,
  score_tally_if.slave bus
);

  localparam logic [7:0]  KEY_START = 8'h2c;
  localparam logic [7:0]  KEY_IDLE  = 8'h01;
  localparam int          KW        = $clog2(N_LANES + 1);
  localparam logic [15:0] HIT_P     = 16'(HIT_POINTS);
  localparam logic [15:0] BONUS_P   = 16'(BONUS_POINTS);
  localparam logic [7:0]  CB_THR    = 8'(COMBO_BONUS);
  localparam logic [7:0]  WIN       = 8'(COMBO_WINDOW);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {B_IDLE, B_SHIFT, B_DONE} bstate_t;

  state_t state, state_nxt;
  logic   go_idle;

  // ---------------- session FSM ----------------
  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    go_idle   = 1'b0;
    case (state)
      S_IDLE: if (bus.keycode == KEY_START) state_nxt = S_RUN;
      S_RUN:  if (bus.keycode == KEY_IDLE) begin
                state_nxt = S_IDLE;
                go_idle   = 1'b1;
              end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- edge detect ----------------
  // Rising edges are captured into hits_q at the sampling edge and counted one
  // edge later. Edges sampled while IDLE are dropped at capture, so a start
  // key coincident with a rise never counts that rise.
  logic [N_LANES-1:0] score_prev, hits_q;
  logic [KW-1:0]      k;

  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      score_prev <= '0;
      hits_q     <= '0;
    end else begin
      score_prev <= bus.score_in;
      hits_q     <= (state == S_RUN) ? (bus.score_in & ~score_prev) : '0;
    end

  always_comb begin
    k = '0;
    for (int i = 0; i < N_LANES; i++) k = k + KW'(hits_q[i]);
  end

  // ---------------- tally ----------------
  logic [13:0] score_total;
  logic [9:0]  hit_count;
  logic [7:0]  combo, max_combo, gap, combo_nxt;
  logic        hit_pulse, hit_ok;
  logic [15:0] combo_sum, pts, cnt_sum;
  logic [16:0] score_sum;

  // A quit key in the same cycle discards the hit.
  assign hit_ok = (state == S_RUN) && !go_idle && (k != '0);

  always_comb begin
    if (combo != 8'd0 && gap < WIN) combo_sum = {8'd0, combo} + 16'(k);
    else                            combo_sum = 16'(k);
    combo_nxt = (combo_sum > 16'd255) ? 8'd255 : combo_sum[7:0];
    pts       = 16'(k) * HIT_P + ((combo_nxt >= CB_THR) ? 16'(k) * BONUS_P : 16'd0);
    score_sum = {3'd0, score_total} + {1'b0, pts};
    cnt_sum   = {6'd0, hit_count} + 16'(k);
  end

  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      score_total <= '0;
      hit_count   <= '0;
      combo       <= '0;
      max_combo   <= '0;
      gap         <= '0;
      hit_pulse   <= 1'b0;
    end else if (go_idle) begin
      score_total <= '0;
      hit_count   <= '0;
      combo       <= '0;
      gap         <= '0;
      hit_pulse   <= 1'b0;
    end else begin
      hit_pulse <= hit_ok;
      if (hit_ok) begin
        score_total <= (score_sum > 17'd9999) ? 14'd9999 : score_sum[13:0];
        hit_count   <= (cnt_sum > 16'd1023) ? 10'd1023 : cnt_sum[9:0];
        combo       <= combo_nxt;
        gap         <= '0;
        if (combo_nxt > max_combo) max_combo <= combo_nxt;
      end else if (gap != 8'd255) begin
        gap <= gap + 8'd1;
      end
    end

  // ---------------- BCD double-dabble ----------------
  // dd_sr = {bcd[15:0], bin[15:0]}; 16 shifts of a zero-extended 16-bit value.
  bstate_t     bst;
  logic [31:0] dd_sr, dd_adj, dd_shift;
  logic [3:0]  dd_cnt;
  logic [13:0] score_seen;
  logic [15:0] score_bcd;
  logic        pending, change;

  assign change = (score_total != score_seen);

  always_comb begin
    dd_adj = dd_sr;
    for (int d = 0; d < 4; d++)
      if (dd_sr[16+4*d +: 4] >= 4'd5) dd_adj[16+4*d +: 4] = dd_sr[16+4*d +: 4] + 4'd3;
    dd_shift = dd_adj << 1;
  end

  always_ff @(posedge frame_clk or negedge Reset_n)
    if (!Reset_n) begin
      bst        <= B_IDLE;
      dd_sr      <= '0;
      dd_cnt     <= '0;
      score_seen <= '0;
      score_bcd  <= '0;
      pending    <= 1'b0;
    end else if (go_idle) begin
      // score_total clears on this edge too, so seen=0 avoids a spurious reload
      bst        <= B_IDLE;
      dd_sr      <= '0;
      dd_cnt     <= '0;
      score_seen <= '0;
      score_bcd  <= '0;
      pending    <= 1'b0;
    end else begin
      score_seen <= score_total;
      case (bst)
        B_IDLE: if (change || pending) begin
          dd_sr   <= {16'd0, 2'b00, score_total};
          dd_cnt  <= '0;
          pending <= 1'b0;
          bst     <= B_SHIFT;
        end
        B_SHIFT: begin
          dd_sr  <= dd_shift;
          dd_cnt <= dd_cnt + 4'd1;
          if (dd_cnt == 4'd15) bst <= B_DONE;
          if (change) pending <= 1'b1;
        end
        B_DONE: begin
          score_bcd <= dd_sr[31:16];
          bst       <= B_IDLE;
          if (change) pending <= 1'b1;
        end
        default: bst <= B_IDLE;
      endcase
    end

  // ---------------- outputs ----------------
  assign bus.running     = (state == S_RUN);
  assign bus.score_total = score_total;
  assign bus.hit_count   = hit_count;
  assign bus.combo       = combo;
  assign bus.max_combo   = max_combo;
  assign bus.hit_pulse   = hit_pulse;
  assign bus.score_bcd   = score_bcd;
  assign bus.bcd_busy    = (bst != B_IDLE);

endmodule

// File: tb/tb_score_tally.sv
module tb_score_tally;
  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 frame_clk = ~frame_clk;

  score_tally_if #(.N_LANES(64)) bus();

  score_tally #(.N_LANES(64)) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    bus.keycode  = 8'h00;
    bus.score_in = '0;
    Reset_n      = 1'b0;
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic key(input logic [7:0] kc);
    bus.keycode = kc;
    tick();
    bus.keycode = 8'h00;
  endtask

  // rise lanes at one edge, drop them before the next; counted on the 2nd edge
  task automatic hit(input logic [63:0] mask);
    bus.score_in = mask;
    tick();
    bus.score_in = '0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({bus.running, bus.score_total, bus.hit_count, bus.combo, bus.max_combo,
                  bus.hit_pulse, bus.score_bcd, bus.bcd_busy} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got score=%0d hits=%0d combo=%0d max=%0d bcd=%h run=%b busy=%b exp all 0",
        bus.score_total, bus.hit_count, bus.combo, bus.max_combo, bus.score_bcd, bus.running, bus.bcd_busy);
    end
  endtask

  task automatic test_single_hit();
    key(8'h2c);
    n_cmp++; if (bus.running !== 1'b1) begin n_bad++; $display("FAIL start_running got %b exp 1", bus.running); end
    bus.score_in[5] = 1'b1;
    tick();
    n_cmp++; if (bus.score_total !== 14'd0) begin n_bad++; $display("FAIL hit_latency got %0d exp 0", bus.score_total); end
    tick();
    n_cmp++; if ({bus.score_total, bus.hit_count, bus.combo, bus.hit_pulse} !== {14'd10, 10'd1, 8'd1, 1'b1}) begin
      n_bad++; $display("FAIL single_hit got score=%0d hits=%0d combo=%0d pulse=%b exp 10/1/1/1",
        bus.score_total, bus.hit_count, bus.combo, bus.hit_pulse);
    end
    tick();
    n_cmp++; if (bus.hit_pulse !== 1'b0) begin n_bad++; $display("FAIL pulse_width got %b exp 0", bus.hit_pulse); end
    repeat (16) tick();
    n_cmp++; if ({bus.bcd_busy, bus.score_bcd} !== {1'b1, 16'h0000}) begin
      n_bad++; $display("FAIL bcd_busy_m17 got busy=%b bcd=%h exp 1/0000", bus.bcd_busy, bus.score_bcd);
    end
    tick();
    n_cmp++; if ({bus.bcd_busy, bus.score_bcd} !== {1'b0, 16'h0010}) begin
      n_bad++; $display("FAIL bcd_m18 got busy=%b bcd=%h exp 0/0010", bus.bcd_busy, bus.score_bcd);
    end
  endtask

  task automatic test_hold();
    repeat (31) tick();
    n_cmp++; if ({bus.score_total, bus.hit_count} !== {14'd10, 10'd1}) begin
      n_bad++; $display("FAIL hold_level got score=%0d hits=%0d exp 10/1", bus.score_total, bus.hit_count);
    end
    bus.score_in[5] = 1'b0;
    repeat (20) tick();
    bus.score_in[5] = 1'b1;
    tick();
    bus.score_in[5] = 1'b0;
    tick();
    n_cmp++; if ({bus.score_total, bus.hit_count, bus.combo} !== {14'd20, 10'd2, 8'd2}) begin
      n_bad++; $display("FAIL rehit got score=%0d hits=%0d combo=%0d exp 20/2/2", bus.score_total, bus.hit_count, bus.combo);
    end
  endtask

  task automatic test_multi();
    key(8'h01);
    key(8'h2c);
    hit(64'hFFF);
    n_cmp++; if ({bus.score_total, bus.hit_count, bus.combo, bus.max_combo} !== {14'd180, 10'd12, 8'd12, 8'd12}) begin
      n_bad++; $display("FAIL multi_hit got score=%0d hits=%0d combo=%0d max=%0d exp 180/12/12/12",
        bus.score_total, bus.hit_count, bus.combo, bus.max_combo);
    end
  endtask

  task automatic test_combo_window();
    do_reset();
    key(8'h2c);
    hit(64'h1); hit(64'h1); hit(64'h1);
    n_cmp++; if ({bus.combo, bus.score_total} !== {8'd3, 14'd30}) begin
      n_bad++; $display("FAIL combo3 got combo=%0d score=%0d exp 3/30", bus.combo, bus.score_total);
    end
    repeat (119) tick();   // next hit sees gap 120
    hit(64'h1);
    n_cmp++; if ({bus.combo, bus.max_combo, bus.score_total} !== {8'd1, 8'd3, 14'd40}) begin
      n_bad++; $display("FAIL gap120 got combo=%0d max=%0d score=%0d exp 1/3/40", bus.combo, bus.max_combo, bus.score_total);
    end
    hit(64'h1); hit(64'h1);
    repeat (118) tick();   // next hit sees gap 119
    hit(64'h1);
    n_cmp++; if ({bus.combo, bus.max_combo, bus.score_total} !== {8'd4, 8'd4, 14'd70}) begin
      n_bad++; $display("FAIL gap119 got combo=%0d max=%0d score=%0d exp 4/4/70", bus.combo, bus.max_combo, bus.score_total);
    end
  endtask

  task automatic test_saturation();
    key(8'h01);
    key(8'h2c);
    hit(64'hFF);                                // 80, combo 8
    repeat (10) hit({64{1'b1}});                // +640*15 -> 9680
    n_cmp++; if ({bus.score_total, bus.combo} !== {14'd9680, 8'd255}) begin
      n_bad++; $display("FAIL preload got score=%0d combo=%0d exp 9680/255", bus.score_total, bus.combo);
    end
    repeat (40) tick();
    n_cmp++; if (bus.score_bcd !== 16'h9680) begin n_bad++; $display("FAIL bcd_9680 got %h exp 9680", bus.score_bcd); end
    hit(64'h1F_FFFF);                           // +21*15 -> 9995
    n_cmp++; if ({bus.score_total, bus.hit_count} !== {14'd9995, 10'd669}) begin
      n_bad++; $display("FAIL score_9995 got score=%0d hits=%0d exp 9995/669", bus.score_total, bus.hit_count);
    end
    hit(64'h1);                                 // lands during the 9995 conversion
    n_cmp++; if (bus.score_total !== 14'd9999) begin n_bad++; $display("FAIL score_clamp got %0d exp 9999", bus.score_total); end
    repeat (16) tick();
    n_cmp++; if (bus.score_bcd !== 16'h9995) begin n_bad++; $display("FAIL bcd_first got %h exp 9995", bus.score_bcd); end
    repeat (17) tick();
    n_cmp++; if (bus.bcd_busy !== 1'b1) begin n_bad++; $display("FAIL bcd_reload_busy got %b exp 1", bus.bcd_busy); end
    tick();
    n_cmp++; if ({bus.bcd_busy, bus.score_bcd} !== {1'b0, 16'h9999}) begin
      n_bad++; $display("FAIL bcd_pending got busy=%b bcd=%h exp 0/9999", bus.bcd_busy, bus.score_bcd);
    end
    repeat (6) hit({64{1'b1}});
    n_cmp++; if ({bus.hit_count, bus.score_total, bus.combo} !== {10'd1023, 14'd9999, 8'd255}) begin
      n_bad++; $display("FAIL count_sat got hits=%0d score=%0d combo=%0d exp 1023/9999/255",
        bus.hit_count, bus.score_total, bus.combo);
    end
  endtask

  task automatic test_exit();
    do_reset();
    key(8'h2c);
    for (int i = 0; i < 4; i++) begin
      hit(64'h7F);
      repeat (119) tick();
    end
    hit(64'h3);
    n_cmp++; if ({bus.score_total, bus.hit_count, bus.combo, bus.max_combo} !== {14'd300, 10'd30, 8'd2, 8'd7}) begin
      n_bad++; $display("FAIL pre_exit got score=%0d hits=%0d combo=%0d max=%0d exp 300/30/2/7",
        bus.score_total, bus.hit_count, bus.combo, bus.max_combo);
    end
    repeat (40) tick();
    n_cmp++; if (bus.score_bcd !== 16'h0300) begin n_bad++; $display("FAIL bcd_300 got %h exp 0300", bus.score_bcd); end
    key(8'h01);
    n_cmp++; if ({bus.running, bus.score_total, bus.hit_count, bus.combo, bus.score_bcd, bus.max_combo} !==
                 {1'b0, 14'd0, 10'd0, 8'd0, 16'h0000, 8'd7}) begin
      n_bad++; $display("FAIL exit_clear got run=%b score=%0d hits=%0d combo=%0d bcd=%h max=%0d exp 0/0/0/0/0000/7",
        bus.running, bus.score_total, bus.hit_count, bus.combo, bus.score_bcd, bus.max_combo);
    end
  endtask

  task automatic test_key_collisions();
    // quit key on the counting edge: the 8-lane hit must not touch max_combo
    key(8'h2c);
    bus.score_in = 64'hFF;
    tick();
    bus.score_in = '0;
    bus.keycode  = 8'h01;
    tick();
    bus.keycode  = 8'h00;
    n_cmp++; if ({bus.running, bus.hit_pulse, bus.hit_count, bus.max_combo} !== {1'b0, 1'b0, 10'd0, 8'd7}) begin
      n_bad++; $display("FAIL quit_with_hit got run=%b pulse=%b hits=%0d max=%0d exp 0/0/0/7",
        bus.running, bus.hit_pulse, bus.hit_count, bus.max_combo);
    end
    // non-start key in IDLE is ignored
    key(8'h05);
    n_cmp++; if (bus.running !== 1'b0) begin n_bad++; $display("FAIL idle_other_key got %b exp 0", bus.running); end
    // start key with a rising edge in the same cycle: edge not counted
    bus.keycode  = 8'h2c;
    bus.score_in = 64'h1;
    tick();
    bus.keycode = 8'h00;
    repeat (2) tick();
    bus.score_in = '0;
    key(8'h2c);            // start key inside RUN is ignored
    n_cmp++; if ({bus.running, bus.hit_count, bus.score_total} !== {1'b1, 10'd0, 14'd0}) begin
      n_bad++; $display("FAIL start_with_edge got run=%b hits=%0d score=%0d exp 1/0/0",
        bus.running, bus.hit_count, bus.score_total);
    end
  endtask

  task automatic test_reset_mid();
    hit(64'h1);
    repeat (3) tick();
    n_cmp++; if ({bus.bcd_busy, bus.score_total} !== {1'b1, 14'd10}) begin
      n_bad++; $display("FAIL pre_reset got busy=%b score=%0d exp 1/10", bus.bcd_busy, bus.score_total);
    end
    Reset_n = 1'b0;
    #1;
    n_cmp++; if ({bus.running, bus.score_total, bus.hit_count, bus.combo, bus.max_combo,
                  bus.hit_pulse, bus.score_bcd, bus.bcd_busy} !== '0) begin
      n_bad++; $display("FAIL async_reset got score=%0d hits=%0d combo=%0d max=%0d bcd=%h run=%b busy=%b exp all 0",
        bus.score_total, bus.hit_count, bus.combo, bus.max_combo, bus.score_bcd, bus.running, bus.bcd_busy);
    end
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.keycode  = 8'h00;
    bus.score_in = '0;
    test_reset();
    test_single_hit();
    test_hold();
    test_multi();
    test_combo_window();
    test_saturation();
    test_exit();
    test_key_collisions();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_tally.md
# score_tally

Score accumulator for the rhythm game, sitting on the receiving end of the droppers' `score` outputs. It collects the per-note `score` levels from up to `N_LANES` droppers and edge-detects new hits. It maintains the running score, hit count and combo streak, and serially converts the score to BCD for the on-screen score display. Session control uses the same keycodes as the droppers: 8'h2c starts a run, 8'h01 returns to idle.

## Interface
- `N_LANES`, 64: number of dropper score inputs.
- `HIT_POINTS`, 10: base points per hit.
- `BONUS_POINTS`, 5: extra points per hit while the combo is at or above `COMBO_BONUS`.
- `COMBO_BONUS`, 10: combo threshold at which the bonus applies.
- `COMBO_WINDOW`, 120: maximum number of frames between hits for the streak to continue.
- `frame_clk`, in, 1: the only clock; all state advances on its rising edge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `keycode`, in, 8: USB keycode. 8'h2c is start, 8'h01 is back to idle.
- `score_in`, in, N_LANES: concatenated dropper `score` levels.
- `running`, out, 1: high while in RUN.
- `score_total`, out, 14: binary score, saturating at 9999.
- `hit_count`, out, 10: total hits, saturating at 1023.
- `combo`, out, 8: current streak, saturating at 255.
- `max_combo`, out, 8: best streak since reset.
- `hit_pulse`, out, 1: one-cycle pulse on any new hit.
- `score_bcd`, out, 16: four BCD digits of `score_total`.
- `bcd_busy`, out, 1: high while a conversion is in progress.

## Operation
- States:
  - IDLE → RUN when keycode == 8'h2c.
  - RUN → IDLE when keycode == 8'h01. Any other keycode is ignored.
- `score_prev` registers `score_in` every cycle in both states.
- `new_hits = score_in & ~score_prev`. These are rising edges only; a held level counts once.
- `k = popcount(new_hits)`, 0..N_LANES. k is used only in RUN; edges seen in IDLE are discarded.
- `gap`: 8-bit frame counter.
  - Cleared on every cycle with k > 0.
  - Otherwise increments, saturating at 255.
- Combo update in RUN when k > 0:
  - If combo > 0 and gap < COMBO_WINDOW, combo_next = combo + k.
  - Otherwise combo_next = k.
  - Saturate at 255.
- Points per cycle = k*HIT_POINTS, plus k*BONUS_POINTS if combo_next ≥ COMBO_BONUS.
  - score_total = min(score_total + points, 9999). Compute the sum with at least 16 bits before clamping.
- hit_count += k, saturating at 1023. max_combo = max(max_combo, combo_next).
- `hit_pulse` is high for the single cycle after a RUN cycle with k > 0.
- BCD converter, double-dabble, one shift per cycle:
  - LOAD captures `score_total`.
  - 16 SHIFT cycles follow, using add-3-if-≥5 on each digit before every shift.
  - DONE writes `score_bcd`.
  - A LOAD is requested whenever `score_total` changes while idle.
  - A change while busy sets `pending`. After DONE, the converter reloads from the current `score_total`.
- RUN → IDLE transition: on the same edge, clear score_total, hit_count, combo, gap, score_bcd and pending, and abort any conversion. max_combo is kept.
- IDLE → RUN transition: counters are already zero. No carry-over.

## Timing
- Reset values: state IDLE, score_prev 0, and every output 0 (including max_combo and score_bcd).
  - Reset is asynchronous on assertion. Deassertion is sampled on the next frame_clk edge.
- Hit latency: the score_in rise is sampled at edge N. score_total, hit_count, combo and hit_pulse update at edge N+1.
- BCD latency: score_total updates at edge M. LOAD happens at M+1, the shifts at M+2..M+17, and DONE writes score_bcd at edge M+18.
  - bcd_busy is high from M+1 through M+17.
- Simultaneous hits in one cycle: all counted, with one combo_next computation and one hit_pulse.
- Keycode 8'h01 in the same cycle as a hit: the transition wins and the hit is discarded.
- Keycode 8'h2c in IDLE in the same cycle as a score_in edge: the edge is not counted, because the state is still IDLE that cycle.
- Saturation of score_total, combo and hit_count is silent. There is no wrap.

## Test plan
- Reset, then 8'h2c. Raise score_in[5] at one edge → one cycle later score_total=10, hit_count=1, combo=1, a single hit_pulse. 18 cycles after that, score_bcd=16'h0010.
- Hold score_in[5] high for 50 cycles → no further increments. Drop it, raise it again 20 frames later → combo=2, score_total=20.
- Raise score_in[0..11] together in one cycle → k=12, combo=12, score_total=12*15=180, hit_count=12.
- With combo=3, wait 120 idle frames, then hit → combo=1 and max_combo stays 3. A hit at gap 119 instead → combo=4.
- Preload to 9995 via repeated hits, then one more bonus hit → score_total=9999, score_bcd=16'h9999. Change score_total during a conversion → the final score_bcd matches the latest value.
- In RUN with score 300 and max_combo 7, assert 8'h01 → score_total, combo and score_bcd are 0 on the next edge and max_combo=7. Assert Reset_n low mid-conversion → all outputs 0 immediately.
